inst_mem_arbiter: RTL

- Shares the single read port of the instruction ROM between two requesters: port 0 (IF-stage fetch) and port 1 (debug/loader read-back).
- Sits between pc_reg/IF and the ROM.
- Drives the ROM chip enable and word address, and returns registered read data with a per-port valid/error.
- Fetch has fixed priority; a starvation counter guarantees debug forward progress.

---
 rtl/inst_mem_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/inst_mem_arbiter.sv
// Two-port arbiter in front of the instruction ROM read port. Fetch (port 0) has fixed
// priority. A starvation counter forces a debug (port 1) win after MaxWait losses.
module inst_mem_arbiter #(
  parameter int InstMemNum     = 512,
  parameter int InstMemNumLog2 = 9,
  parameter int MaxWait        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_inst,
  output logic [3:0]  starve_cnt_o
);

  localparam int unsigned    WORDS_I   = InstMemNum;
  localparam int unsigned    MAXWAIT_I = MaxWait;
  localparam logic [3:0]     MAX_WAIT  = MAXWAIT_I[3:0];
  localparam logic [InstMemNumLog2:0] WORDS = WORDS_I[InstMemNumLog2:0];

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rvalid0_q, rvalid1_q, err0_q, err1_q;
  logic [31:0] rdata0_q, rdata1_q;

  logic        force_dbg;
  logic        win0, win1;
  logic [31:0] win_addr;
  logic        win_legal;
  logic        illegal;

  // Fetch wins by default; a debug request that has lost MaxWait times in a row wins outright.
  always_comb begin
    force_dbg = req1 && (starve_cnt_q >= MAX_WAIT);
    win0      = 1'b0;
    win1      = 1'b0;
    if (rst) begin
      if (force_dbg)  win1 = 1'b1;
      else if (req0)  win0 = 1'b1;
      else if (req1)  win1 = 1'b1;
    end
  end

  assign win_addr = win1 ? addr1 : addr0;

  // Word index must fall inside the ROM and the byte address must be word aligned.
  assign win_legal = (win_addr[1:0] == 2'b00) &&
                     (win_addr[31:InstMemNumLog2+2] == '0) &&
                     ({1'b0, win_addr[InstMemNumLog2+1:2]} < WORDS);
  assign illegal   = !win_legal;

  assign gnt0     = win0;
  assign gnt1     = win1;
  assign mem_ce   = (win0 || win1) && win_legal;
  assign mem_addr = mem_ce ? win_addr : 32'h0;

  always_comb begin
    starve_cnt_d = 4'd0;
    if (req1 && !win1)
      starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt_q <= 4'd0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      rdata0_q     <= 32'h0;
      rdata1_q     <= 32'h0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rvalid0_q    <= win0;
      rvalid1_q    <= win1;
      err0_q       <= win0 && illegal;
      err1_q       <= win1 && illegal;
      // Read data only updates for the port that won; the loser keeps its last word.
      if (win0) rdata0_q <= illegal ? 32'h0 : mem_inst;
      if (win1) rdata1_q <= illegal ? 32'h0 : mem_inst;
    end
  end

  assign rvalid0      = rvalid0_q;
  assign rvalid1      = rvalid1_q;
  assign err0         = err0_q;
  assign err1         = err1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign starve_cnt_o = starve_cnt_q;

endmodule
